frame_writer: RTL and testbench

//  Sits directly downstream of the painter. It accepts one painted pixel (x, y, palette) per cycle and writes it into the

---
 rtl/runner_pkg.sv | 16 +
 rtl/frame_writer_pixel_addr_pipe.sv | 72 +++++++
 rtl/frame_writer.sv | 120 ++++++++++++
 tb/tb_frame_writer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/runner_pkg.sv
// Shared types and screen constants for the frame writer.
package runner_pkg;

  typedef enum logic [2:0] {
    RESTART,
    PAINT,
    DRAIN,
    WAIT_VSYNC,
    SWAP
  } fw_state_t;

  localparam int         SCREEN_W            = 800;
  localparam int         SCREEN_H            = 480;
  localparam logic [2:0] PALETTE_TRANSPARENT = 3'd7;

endpackage

// File: rtl/frame_writer_pixel_addr_pipe.sv
// Two-stage pixel filter and framebuffer address pipeline.
// Stage 1 registers the pixel and its keep decision; stage 2 issues the write.
module pixel_addr_pipe #(
  parameter int         COOR_WIDTH  = 12,
  parameter int         H_ACTIVE    = 800,
  parameter int         V_ACTIVE    = 480,
  parameter logic [2:0] TRANSPARENT = 3'd7,
  parameter int         PIX_WIDTH   = 19
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [COOR_WIDTH-1:0] i_x,
  input  logic [COOR_WIDTH-1:0] i_y,
  input  logic [2:0]            i_palette,
  input  logic                  i_bank,
  output logic                  o_we,
  output logic [PIX_WIDTH:0]    o_addr,
  output logic [2:0]            o_data
);

  localparam logic [COOR_WIDTH-1:0] X_LIM = COOR_WIDTH'(H_ACTIVE);
  localparam logic [COOR_WIDTH-1:0] Y_LIM = COOR_WIDTH'(V_ACTIVE);
  localparam logic [PIX_WIDTH-1:0]  LINE  = PIX_WIDTH'(H_ACTIVE);

  logic                  r_keep;
  logic [COOR_WIDTH-1:0] r_x;
  logic [COOR_WIDTH-1:0] r_y;
  logic [2:0]            r_pal;
  logic                  r_we;
  logic [PIX_WIDTH:0]    r_addr;
  logic [2:0]            r_data;
  logic [PIX_WIDTH-1:0]  w_index;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_keep <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_pal  <= '0;
    end else begin
      r_keep <= i_valid && (i_x < X_LIM) && (i_y < Y_LIM) && (i_palette != TRANSPARENT);
      r_x    <= i_x;
      r_y    <= i_y;
      r_pal  <= i_palette;
    end
  end

  // Only kept pixels reach here meaningfully, so the index never needs more than PIX_WIDTH bits.
  always_comb begin
    w_index = PIX_WIDTH'(r_y) * LINE + PIX_WIDTH'(r_x);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= r_keep;
      if (r_keep) begin
        r_addr <= {i_bank, w_index};
        r_data <= r_pal;
      end
    end
  end

  assign o_we   = r_we;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/frame_writer.sv
// Writes painter output into the back framebuffer bank and swaps banks on the
// first vsync after a frame is fully painted and drained.
module frame_writer
  import runner_pkg::*;
#(
  parameter int         COOR_WIDTH  = 12,
  parameter int         H_ACTIVE    = SCREEN_W,
  parameter int         V_ACTIVE    = SCREEN_H,
  parameter logic [2:0] TRANSPARENT = PALETTE_TRANSPARENT,
  parameter int         PIX_WIDTH   = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic                  clk_33m,
  input  logic                  rst,
  input  logic                  paint_valid,
  input  logic [COOR_WIDTH-1:0] paint_x,
  input  logic [COOR_WIDTH-1:0] paint_y,
  input  logic [2:0]            paint_palette,
  input  logic                  paint_finished,
  input  logic                  vsync,
  output logic                  painter_rst,
  output logic                  mem_we,
  output logic [PIX_WIDTH:0]    mem_addr,
  output logic [2:0]            mem_data,
  output logic                  display_bank,
  output logic                  frame_dropped
);

  fw_state_t             r_state;
  logic                  r_painter_rst;
  logic                  r_bank;
  logic                  r_drop;
  logic                  r_drain_cnt;
  logic                  r_first;
  logic                  w_painting;
  logic                  w_valid;
  logic [COOR_WIDTH-1:0] w_x;
  logic [COOR_WIDTH-1:0] w_y;
  logic [2:0]            w_pal;

  always_comb begin
    w_painting = (r_state == PAINT);
    w_valid    = paint_valid && w_painting;
    w_x        = w_painting ? paint_x : '0;
    w_y        = w_painting ? paint_y : '0;
    w_pal      = w_painting ? paint_palette : '0;
  end

  // r_first masks a stale finished flag on the first PAINT cycle after a painter reset.
  always_ff @(posedge clk_33m) begin
    if (rst) begin
      r_state       <= RESTART;
      r_painter_rst <= 1'b1;
      r_bank        <= 1'b0;
      r_drop        <= 1'b0;
      r_drain_cnt   <= 1'b0;
      r_first       <= 1'b1;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        RESTART: begin
          r_state       <= PAINT;
          r_painter_rst <= 1'b0;
          r_first       <= 1'b1;
          if (vsync) r_drop <= 1'b1;
        end
        PAINT: begin
          r_first <= 1'b0;
          if (vsync) r_drop <= 1'b1;
          if (paint_finished && !r_first) begin
            r_state     <= DRAIN;
            r_drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          if (vsync) r_drop <= 1'b1;
          r_drain_cnt <= ~r_drain_cnt;
          if (r_drain_cnt) r_state <= WAIT_VSYNC;
        end
        WAIT_VSYNC: begin
          if (vsync) begin
            r_state <= SWAP;
            r_bank  <= ~r_bank;
          end
        end
        SWAP: begin
          r_state       <= RESTART;
          r_painter_rst <= 1'b1;
        end
        default: begin
          r_state       <= RESTART;
          r_painter_rst <= 1'b1;
        end
      endcase
    end
  end

  pixel_addr_pipe #(
    .COOR_WIDTH (COOR_WIDTH),
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .TRANSPARENT(TRANSPARENT),
    .PIX_WIDTH  (PIX_WIDTH)
  ) u_pipe (
    .i_clk    (clk_33m),
    .i_rst    (rst),
    .i_valid  (w_valid),
    .i_x      (w_x),
    .i_y      (w_y),
    .i_palette(w_pal),
    .i_bank   (~r_bank),
    .o_we     (mem_we),
    .o_addr   (mem_addr),
    .o_data   (mem_data)
  );

  assign painter_rst   = r_painter_rst;
  assign display_bank  = r_bank;
  assign frame_dropped = r_drop;

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer: vector table, hand-written bank/drop
// sequences, and randomized traffic against a frame-timeline reference model.
module tb_frame_writer;

  logic        clk_33m = 1'b0;
  logic        rst = 1'b1;
  logic        paint_valid = 1'b0;
  logic [11:0] paint_x = '0;
  logic [11:0] paint_y = '0;
  logic [2:0]  paint_palette = '0;
  logic        paint_finished = 1'b0;
  logic        vsync = 1'b0;
  logic        painter_rst;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [2:0]  mem_data;
  logic        display_bank;
  logic        frame_dropped;

  always #15 clk_33m = ~clk_33m;

  frame_writer dut (
    .clk_33m       (clk_33m),
    .rst           (rst),
    .paint_valid   (paint_valid),
    .paint_x       (paint_x),
    .paint_y       (paint_y),
    .paint_palette (paint_palette),
    .paint_finished(paint_finished),
    .vsync         (vsync),
    .painter_rst   (painter_rst),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .display_bank  (display_bank),
    .frame_dropped (frame_dropped)
  );

  typedef struct {
    bit we;
    int addr;
    int data;
  } wr_t;

  typedef struct {
    bit v;
    int x;
    int y;
    int pal;
    bit we;
    int idx;
  } vec_t;

  int  n_vec = 0;
  int  n_err = 0;
  int  cyc;
  int  t_restart, t_finish, t_vs;
  bit  m_bank, exp_drop;
  int  h_addr, h_data;
  wr_t pq[$];
  vec_t tbl[10];

  task automatic tick();
    @(posedge clk_33m);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Frame timeline: RESTART at t_restart, PAINT after it until the honoured finish,
  // two drain cycles, then waiting until vsync; bank flips one cycle after that vsync.
  task automatic step(input bit v, input int x, input int y, input int pal,
                      input bit fin, input bit vs);
    wr_t e;
    bit  is_restart, is_paint, is_drain, is_wait;
    if (t_vs >= 0 && cyc == t_vs + 1) m_bank = ~m_bank;
    if (t_vs >= 0 && cyc == t_vs + 2) begin
      t_restart = cyc;
      t_finish  = -1;
      t_vs      = -1;
    end
    chk("painter_rst", painter_rst, cyc == t_restart);
    chk("display_bank", display_bank, m_bank);
    chk("frame_dropped", frame_dropped, exp_drop);
    e = pq.pop_front();
    if (e.we) begin
      h_addr = e.addr;
      h_data = e.data;
    end
    chk("mem_we", mem_we, e.we);
    chk("mem_addr", mem_addr, h_addr);
    chk("mem_data", mem_data, h_data);

    is_restart = (cyc == t_restart);
    is_paint   = (cyc > t_restart) && (t_finish < 0 || cyc <= t_finish);
    is_drain   = (t_finish >= 0) && (cyc > t_finish) && (cyc <= t_finish + 2);
    is_wait    = (t_finish >= 0) && (cyc >= t_finish + 3) && (t_vs < 0);

    paint_valid    = v;
    paint_x        = 12'(x);
    paint_y        = 12'(y);
    paint_palette  = 3'(pal);
    paint_finished = fin;
    vsync          = vs;

    exp_drop = vs && (is_restart || is_paint || is_drain);
    if (is_paint && cyc >= t_restart + 2 && fin) t_finish = cyc;
    if (is_wait && vs) t_vs = cyc;
    e.we   = is_paint && v && x < 800 && y < 480 && pal != 7;
    e.addr = (m_bank ? 0 : 524288) + y * 800 + x;
    e.data = pal;
    pq.push_back(e);
    tick();
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      paint_valid    = 1'b1;
      paint_x        = 12'($urandom_range(0, 799));
      paint_y        = 12'($urandom_range(0, 479));
      paint_palette  = 3'($urandom_range(0, 6));
      paint_finished = 1'b0;
      vsync          = 1'b0;
      tick();
      chk("rst_painter_rst", painter_rst, 1);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_display_bank", display_bank, 0);
      chk("rst_frame_dropped", frame_dropped, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data", mem_data, 0);
    end
    rst         = 1'b0;
    paint_valid = 1'b0;
    cyc       = 0;
    t_restart = 0;
    t_finish  = -1;
    t_vs      = -1;
    m_bank    = 1'b0;
    exp_drop  = 1'b0;
    h_addr    = 0;
    h_data    = 0;
    pq.delete();
    pq.push_back('{we: 1'b0, addr: 0, data: 0});
    pq.push_back('{we: 1'b0, addr: 0, data: 0});
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 15) == 0) ? 4095 : $urandom_range(0, 830),
           ($urandom_range(0, 15) == 0) ? 4095 : $urandom_range(0, 500),
           $urandom_range(0, 7),
           $urandom_range(0, 40) == 0,
           $urandom_range(0, 30) == 0);
    end
  endtask

  initial begin
    tbl[0] = '{v: 1, x: 10,   y: 2,    pal: 3, we: 1, idx: 1610};
    tbl[1] = '{v: 1, x: 800,  y: 0,    pal: 1, we: 0, idx: 0};
    tbl[2] = '{v: 1, x: 0,    y: 480,  pal: 1, we: 0, idx: 0};
    tbl[3] = '{v: 1, x: 5,    y: 5,    pal: 7, we: 0, idx: 0};
    tbl[4] = '{v: 0, x: 3,    y: 3,    pal: 2, we: 0, idx: 0};
    tbl[5] = '{v: 1, x: 799,  y: 479,  pal: 2, we: 1, idx: 383999};
    tbl[6] = '{v: 1, x: 4095, y: 0,    pal: 1, we: 0, idx: 0};
    tbl[7] = '{v: 1, x: 0,    y: 4095, pal: 1, we: 0, idx: 0};
    tbl[8] = '{v: 1, x: 0,    y: 0,    pal: 0, we: 1, idx: 0};
    tbl[9] = '{v: 1, x: 799,  y: 0,    pal: 6, we: 1, idx: 799};

    do_reset(3);
    idle(1);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].pal, 0, 0);
      idle(1);
      chk("tbl_we", mem_we, tbl[i].we);
      if (tbl[i].we) begin
        chk("tbl_addr", mem_addr, 524288 + tbl[i].idx);
        chk("tbl_data", mem_data, tbl[i].pal);
      end
    end

    // Finish, then vsync five cycles later.
    step(0, 0, 0, 0, 1, 0);
    idle(4);
    step(0, 0, 0, 0, 0, 1);
    chk("swap_bank", display_bank, 1);
    idle(1);
    chk("swap_painter_rst", painter_rst, 1);
    idle(1);
    step(1, 1, 1, 5, 0, 0);
    idle(1);
    chk("bank0_we", mem_we, 1);
    chk("bank0_addr", mem_addr, 801);

    // vsync while painting.
    step(0, 0, 0, 0, 0, 1);
    chk("drop_pulse", frame_dropped, 1);
    chk("drop_bank", display_bank, 1);
    idle(1);
    chk("drop_clear", frame_dropped, 0);

    // Finished held high throughout; vsync on the last drain cycle is not captured.
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("drain_vs_drop", frame_dropped, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("drain_vs_no_swap", display_bank, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("second_vs_swap", display_bank, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("restart_pulse", painter_rst, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 799, 479, 2, 0, 0);
    idle(1);
    chk("held_fin_we", mem_we, 1);
    chk("held_fin_addr", mem_addr, 524288 + 383999);

    rand_steps(2000);

    // Steer to bank 1 displayed and painting, then reset during a pixel burst.
    for (int i = 0; i < 80; i++) begin
      if (m_bank && t_finish < 0 && cyc > t_restart) break;
      step(0, 0, 0, 0, 1, 1);
    end
    chk("bank_setup", display_bank, 1);
    for (int i = 0; i < 5; i++)
      step(1, $urandom_range(0, 799), $urandom_range(0, 479), $urandom_range(0, 6), 0, 0);
    do_reset(1);
    rand_steps(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
